// File: rtl/zeroriscy_hpm_counters_if.sv
// -----------------------------------------------------------------------------
// zeroriscy_hpm_counters_if
// CSR access port between the zero-riscy CSR file and the hardware performance
// monitor.
//   csr_access_i  CSR instruction present in ID
//   csr_addr_i    12-bit CSR address
//   csr_wdata_i   32-bit operand
//   csr_op_i      NONE / WRITE / SET / CLEAR
//   csr_rdata_o   combinational read data, 0 when csr_hit_o is low
//   csr_hit_o     address belongs to the monitor and csr_access_i is high
// The master modport is the CSR file side; the slave modport is the monitor.
// -----------------------------------------------------------------------------
interface zeroriscy_hpm_counters_if;
    logic        csr_access_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;

    modport master (
        output csr_access_i, csr_addr_i, csr_wdata_i, csr_op_i,
        input  csr_rdata_o, csr_hit_o
    );

    modport slave (
        input  csr_access_i, csr_addr_i, csr_wdata_i, csr_op_i,
        output csr_rdata_o, csr_hit_o
    );
endinterface

// File: rtl/zeroriscy_hpm_counters.sv
// -----------------------------------------------------------------------------
// zeroriscy_hpm_counters
// Hardware performance monitor: mcycle, minstret and N_CNT programmable event
// counters of CNT_W bits, per-counter inhibit, WARL event selectors, sticky
// overflow flags and a registered overflow interrupt.
//   clk          core clock
//   rst_n        asynchronous active-low reset
//   csr          CSR access port (slave side)
//   instr_ret_i  one instruction retired this cycle
//   event_i      event pulses, one per bit per cycle
//   ovf_irq_o    registered |(overflow flags & overflow enables)
// Counter slot map (inhibit/ovf/ovfen bit positions): slot 0 mcycle, slot 1
// unused (reads 0), slot 2 minstret, slot 3+k programmable counter k.
// -----------------------------------------------------------------------------
module zeroriscy_hpm_counters #(
    parameter int N_CNT = 4,
    parameter int N_EVT = 16,
    parameter int CNT_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    zeroriscy_hpm_counters_if.slave   csr,
    input  logic                      instr_ret_i,
    input  logic [N_EVT-1:0]          event_i,
    output logic                      ovf_irq_o
);
    localparam int NS    = 3 + N_CNT;
    localparam int EVS_W = $clog2(N_EVT + 1);
    localparam logic [63:0] SLOT_ONES  = (64'd1 << NS) - 64'd1;
    localparam logic [31:0] VALID_MASK = SLOT_ONES[31:0] & ~32'h2;

    typedef enum logic [1:0] {
        CSR_OP_NONE  = 2'd0,
        CSR_OP_WRITE = 2'd1,
        CSR_OP_SET   = 2'd2,
        CSR_OP_CLEAR = 2'd3
    } csr_op_e;

    logic [CNT_W-1:0] r_cnt [NS];
    logic [EVS_W-1:0] r_evs [N_CNT];
    logic [NS-1:0]    r_inc;
    logic [31:0]      r_inh;
    logic [31:0]      r_ovf;
    logic [31:0]      r_ovf_en;
    logic             r_irq;

    logic [NS-1:0]    w_lo_sel;
    logic [NS-1:0]    w_hi_sel;
    logic [N_CNT-1:0] w_evt_sel;
    logic             w_inh_sel;
    logic             w_ovf_sel;
    logic             w_ovfen_sel;
    logic             w_dec;
    logic [31:0]      w_rdata_raw;
    logic             w_we;
    logic [31:0]      w_wval;
    logic [NS-1:0]    w_src;
    logic [NS-1:0]    w_ovf_set;
    logic [CNT_W-1:0] w_cnt_nxt [NS];

    // Address decode and read mux.
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        w_lo_sel    = '0;
        w_hi_sel    = '0;
        w_evt_sel   = '0;
        w_inh_sel   = 1'b0;
        w_ovf_sel   = 1'b0;
        w_ovfen_sel = 1'b0;
        w_rdata_raw = '0;
        for (int i = 0; i < NS; i++) begin
            if (i != 1) begin
                if (csr.csr_addr_i == 12'(12'hB00 + i)) begin
                    w_lo_sel[i] = 1'b1;
                    w_rdata_raw = r_cnt[i][31:0];
                end
                if (csr.csr_addr_i == 12'(12'hB80 + i)) begin
                    w_hi_sel[i] = 1'b1;
                    w_rdata_raw = 32'(r_cnt[i][CNT_W-1:32]);
                end
            end
        end
        for (int k = 0; k < N_CNT; k++) begin
            if (csr.csr_addr_i == 12'(12'h323 + k)) begin
                w_evt_sel[k] = 1'b1;
                w_rdata_raw  = 32'(r_evs[k]);
            end
        end
        if (csr.csr_addr_i == 12'h320) begin
            w_inh_sel   = 1'b1;
            w_rdata_raw = r_inh;
        end
        if (csr.csr_addr_i == 12'h7C0) begin
            w_ovf_sel   = 1'b1;
            w_rdata_raw = r_ovf;
        end
        if (csr.csr_addr_i == 12'h7C1) begin
            w_ovfen_sel = 1'b1;
            w_rdata_raw = r_ovf_en;
        end
        w_dec = (|w_lo_sel) | (|w_hi_sel) | (|w_evt_sel) | w_inh_sel | w_ovf_sel | w_ovfen_sel;
    end

    assign csr.csr_hit_o   = csr.csr_access_i & w_dec;
    assign csr.csr_rdata_o = csr.csr_hit_o ? w_rdata_raw : 32'h0;
    assign w_we            = csr.csr_hit_o && (csr_op_e'(csr.csr_op_i) != CSR_OP_NONE);

    // Read-modify-write value; "old" is the value being read this cycle.
    always_comb begin
        unique case (csr_op_e'(csr.csr_op_i))
            CSR_OP_WRITE: w_wval = csr.csr_wdata_i;
            CSR_OP_SET:   w_wval = csr.csr_rdata_o | csr.csr_wdata_i;
            CSR_OP_CLEAR: w_wval = csr.csr_rdata_o & ~csr.csr_wdata_i;
            default:      w_wval = csr.csr_rdata_o;
        endcase
    end

    // Increment sources per slot; selector 0 never counts, v selects event_i[v-1].
    always_comb begin
        w_src    = '0;
        w_src[0] = 1'b1;
        w_src[2] = instr_ret_i;
        for (int k = 0; k < N_CNT; k++) begin
            for (int j = 0; j < N_EVT; j++) begin
                if (r_evs[k] == EVS_W'(j + 1)) begin
                    w_src[3 + k] = event_i[j];
                end
            end
        end
    end

    // Next counter values: a CSR write to either half of a counter drops its
    // pending increment for the whole counter.
    always_comb begin
        w_ovf_set = '0;
        for (int i = 0; i < NS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (w_we && w_lo_sel[i]) begin
                w_cnt_nxt[i][31:0] = w_wval;
            end else if (w_we && w_hi_sel[i]) begin
                w_cnt_nxt[i][CNT_W-1:32] = w_wval[CNT_W-33:0];
            end else if (r_inc[i]) begin
                w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                w_ovf_set[i] = &r_cnt[i];
            end
        end
    end

    // NOTE: the counter and selector arrays are ordinary flops, not a RAM, so
    // every element is cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NS; i++) begin
                r_cnt[i] <= '0;
            end
            for (int k = 0; k < N_CNT; k++) begin
                r_evs[k] <= '0;
            end
            r_inc    <= '0;
            r_inh    <= '0;
            r_ovf    <= '0;
            r_ovf_en <= '0;
            r_irq    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of every other register.
            for (int i = 0; i < NS; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            // Sources are gated by the inhibit value in force this cycle.
            r_inc <= w_src & ~r_inh[NS-1:0];
            if (w_we && w_inh_sel) begin
                r_inh <= w_wval & VALID_MASK;
            end
            for (int k = 0; k < N_CNT; k++) begin
                if (w_we && w_evt_sel[k]) begin
                    r_evs[k] <= (w_wval > 32'(N_EVT)) ? '0 : w_wval[EVS_W-1:0];
                end
            end
            // Hardware overflow set is OR-ed after the software update so it wins.
            r_ovf <= ((w_we && w_ovf_sel) ? (w_wval & VALID_MASK) : r_ovf) | 32'(w_ovf_set);
            if (w_we && w_ovfen_sel) begin
                r_ovf_en <= w_wval & VALID_MASK;
            end
            r_irq <= |(r_ovf & r_ovf_en);
        end
    end

    assign ovf_irq_o = r_irq;
endmodule
